// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: a 256x32 program ROM, a 2-entry prefetch FIFO and an
// IDLE/RUN/HALTED controller. Word 32'hFFFFFFFF acts as a halt sentinel.
// Optional feature: define IFU_REDIRECT_EN to build the branch-redirect path;
// without it, redirect/redirect_pc are ignored and fetch is strictly sequential.
module instr_fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        load_en,
  input  logic [7:0]  load_addr,
  input  logic [31:0] load_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        halted
);

  localparam logic [31:0] SENTINEL = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        sentinel_q, sentinel_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] data0_q, data0_d, pc0_q, pc0_d;
  logic [31:0] data1_q, data1_d, pc1_q, pc1_d;

  logic [31:0] rom [256];
  logic [31:0] rom_rdata_q;
  logic        issue;
  logic [7:0]  rd_idx;

  logic        pop;
  logic        sentinel_hit;
  logic        push;
  logic [2:0]  occupancy;

`ifdef IFU_REDIRECT_EN
  logic        redirect_fire;
  logic [31:0] redirect_target;
  logic        unused_redirect_lsb;
  assign redirect_fire       = redirect & run & (state_q != S_IDLE);
  assign redirect_target     = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];
`else
  logic unused_redirect;
  assign unused_redirect = ^{redirect, redirect_pc};
`endif

  // The word returned this cycle is either enqueued or, if it is the sentinel, swallowed.
  assign pop          = (count_q != 2'd0) & instr_ready;
  assign sentinel_hit = inflight_q & (rom_rdata_q == SENTINEL);
  assign push         = inflight_q & ~sentinel_hit;
  // Occupancy after this cycle's transfer; a new read is allowed while it stays below 2,
  // which keeps one transfer per cycle sustainable without ever overfilling the FIFO.
  assign occupancy    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  // State register plus all datapath flops; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      pc_q          <= 32'd0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      sentinel_q    <= 1'b0;
      count_q       <= 2'd0;
      data0_q       <= 32'd0;
      pc0_q         <= 32'd0;
      data1_q       <= 32'd0;
      pc1_q         <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      sentinel_q    <= sentinel_d;
      count_q       <= count_d;
      data0_q       <= data0_d;
      pc0_q         <= pc0_d;
      data1_q       <= data1_d;
      pc1_q         <= pc1_d;
    end
  end

  // Program ROM: load port writes only while idle; registered read, not touched by reset.
  always_ff @(posedge clk) begin
    if (load_en && (state_q == S_IDLE)) rom[load_addr] <= load_data;
    if (issue) rom_rdata_q <= rom[rd_idx];
  end

  // Next-state logic for the IDLE/RUN/HALTED controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_RUN;
      S_RUN: begin
        if (!run) state_d = S_IDLE;
`ifdef IFU_REDIRECT_EN
        else if (redirect_fire) state_d = S_RUN;
`endif
        else if (sentinel_q && (count_q == 2'd0)) state_d = S_HALTED;
      end
      S_HALTED: begin
        if (!run) state_d = S_IDLE;
`ifdef IFU_REDIRECT_EN
        else if (redirect_fire) state_d = S_RUN;
`endif
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Fetch datapath: read issue, pc advance and FIFO push/pop (head always in entry 0).
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    sentinel_d    = sentinel_q;
    count_d       = count_q;
    data0_d       = data0_q;
    pc0_d         = pc0_q;
    data1_d       = data1_q;
    pc1_d         = pc1_q;
    issue         = 1'b0;
    rd_idx        = pc_q[9:2];
    if (!run || (state_q == S_IDLE)) begin
      pc_d       = 32'd0;
      sentinel_d = 1'b0;
      count_d    = 2'd0;
    end
`ifdef IFU_REDIRECT_EN
    else if (redirect_fire) begin
      // The transfer presented this cycle still completes; everything behind it is dropped
      // and the target word is read right away.
      sentinel_d    = 1'b0;
      count_d       = 2'd0;
      issue         = 1'b1;
      rd_idx        = redirect_target[9:2];
      inflight_d    = 1'b1;
      inflight_pc_d = redirect_target;
      pc_d          = redirect_target + 32'd4;
    end
`endif
    else begin
      sentinel_d = sentinel_q | sentinel_hit;
      case ({pop, push})
        2'b10: begin
          data0_d = data1_q;
          pc0_d   = pc1_q;
          count_d = count_q - 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd0) begin
            data0_d = rom_rdata_q;
            pc0_d   = inflight_pc_q;
          end else begin
            data1_d = rom_rdata_q;
            pc1_d   = inflight_pc_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            data0_d = rom_rdata_q;
            pc0_d   = inflight_pc_q;
          end else begin
            data0_d = data1_q;
            pc0_d   = pc1_q;
            data1_d = rom_rdata_q;
            pc1_d   = inflight_pc_q;
          end
        end
        default: ;
      endcase
      issue = (state_q == S_RUN) && !sentinel_q && !sentinel_hit && (occupancy < 3'd2);
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + 32'd4;
      end
    end
  end

  // Output decode: valid whenever the FIFO holds a word, halted only in HALTED.
  always_comb begin
    instr_valid = (count_q != 2'd0);
    halted      = (state_q == S_HALTED);
  end

  assign instruction = data0_q;
  assign instr_pc    = pc0_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. A spec-level model (expected next pc
// plus a copy of the ROM) checks every transfer and every idle/hold/halt cycle;
// directed scenarios add hand-computed literal expectations.
module tb_instr_fetch_unit;

  localparam logic [31:0] SENT = 32'hFFFF_FFFF;
`ifdef IFU_REDIRECT_EN
  localparam bit REDIR = 1'b1;
`else
  localparam bit REDIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, run, load_en, redirect, instr_ready;
  logic [7:0]  load_addr;
  logic [31:0] load_data, redirect_pc;
  logic [31:0] instruction, instr_pc;
  logic        instr_valid, halted;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .run(run),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .halted(halted)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [31:0] rom_model [256];
  logic        m_active = 1'b0;
  logic [31:0] exp_pc = 32'd0;
  int          xfer_cyc[$];
  logic [31:0] xfer_pc[$];
  logic [31:0] xfer_data[$];

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] get_pc(input int i);
    return (xfer_pc.size() > i) ? xfer_pc[i] : 32'hDEAD_DEAD;
  endfunction
  function automatic logic [31:0] get_data(input int i);
    return (xfer_data.size() > i) ? xfer_data[i] : 32'hDEAD_DEAD;
  endfunction
  function automatic int get_cyc(input int i);
    return (xfer_cyc.size() > i) ? xfer_cyc[i] : -100;
  endfunction

  task automatic clear_log();
    xfer_cyc.delete();
    xfer_pc.delete();
    xfer_data.delete();
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Compare process: every cycle, away from the rising edge.
  initial begin
    logic        hold_pend;
    logic [31:0] hold_instr, hold_pc, exp_w;
    hold_pend = 1'b0;
    hold_instr = 32'd0;
    hold_pc = 32'd0;
    forever begin
      @(negedge clk);
      if (!m_active)
        chk(!instr_valid && !halted, "idle_outputs", {30'd0, instr_valid, halted}, 32'd0);
      if (hold_pend) begin
        chk(instr_valid && instruction == hold_instr, "hold_instruction", instruction, hold_instr);
        chk(instr_valid && instr_pc == hold_pc, "hold_pc", instr_pc, hold_pc);
      end
      if (halted)
        chk(!instr_valid && rom_model[exp_pc[9:2]] == SENT, "halt_at_sentinel", exp_pc, exp_pc);
      if (instr_valid && instr_ready) begin
        exp_w = rom_model[exp_pc[9:2]];
        chk(exp_w != SENT && instr_pc == exp_pc, "xfer_pc", instr_pc, exp_pc);
        chk(exp_w != SENT && instruction == exp_w, "xfer_data", instruction, exp_w);
        $display("[TB] cycle %0d transfer pc=%h instr=%h", cyc, instr_pc, instruction);
        xfer_cyc.push_back(cyc);
        xfer_pc.push_back(instr_pc);
        xfer_data.push_back(instruction);
        exp_pc = exp_pc + 32'd4;
      end
      hold_pend = rst && run && instr_valid && !instr_ready && !(REDIR && m_active && redirect);
      hold_instr = instruction;
      hold_pc = instr_pc;
      if (load_en && !m_active) rom_model[load_addr] = load_data;
      if (!rst || !run) begin
        m_active = 1'b0;
        exp_pc = 32'd0;
      end else begin
        if (REDIR && m_active && redirect) exp_pc = {redirect_pc[31:2], 2'b00};
        m_active = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic wait_halted(input int limit);
    for (int i = 0; i < limit && !halted; i++) step();
    chk(halted, "halted_reached", {31'd0, halted}, 32'd1);
  endtask

  initial begin
    int t0;
    rst = 1'b0; run = 1'b0; load_en = 1'b0; load_addr = 8'd0; load_data = 32'd0;
    redirect = 1'b0; redirect_pc = 32'd0; instr_ready = 1'b0;
    for (int i = 0; i < 256; i++) rom_model[i] = 32'd0;
    step();
    step();
    chk(instr_valid == 1'b0, "reset_valid", {31'd0, instr_valid}, 32'd0);
    chk(instr_pc == 32'd0, "reset_pc", instr_pc, 32'd0);
    chk(instruction == 32'd0, "reset_instr", instruction, 32'd0);
    chk(halted == 1'b0, "reset_halted", {31'd0, halted}, 32'd0);
    rst = 1'b1;

    // Sequential fetch to the sentinel.
    load(8'd0, 32'h014C7020);
    load(8'd1, 32'h0203F022);
    load(8'd2, 32'h01567024);
    load(8'd3, SENT);
    clear_log();
    instr_ready = 1'b1;
    run = 1'b1;
    t0 = cyc;
    wait_halted(40);
    chk(xfer_pc.size() == 3, "seq_count", xfer_pc.size(), 32'd3);
    chk(get_pc(0) == 32'h0 && get_pc(1) == 32'h4 && get_pc(2) == 32'h8, "seq_pcs", get_pc(2), 32'h8);
    chk(get_data(2) == 32'h01567024, "seq_data2", get_data(2), 32'h01567024);
    // RUN is entered at the edge after run rises; first valid two cycles later.
    chk(get_cyc(0) - t0 == 3, "seq_latency", get_cyc(0) - t0, 32'd3);
    chk(get_cyc(2) - get_cyc(0) == 2, "seq_back_to_back", get_cyc(2) - get_cyc(0), 32'd2);

    // Backpressure, with a load attempt while running.
    run = 1'b0;
    step();
    instr_ready = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 10 && !instr_valid; i++) step();
    chk(instr_valid, "bp_valid_seen", {31'd0, instr_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) load(8'h02, 32'hDEADBEEF);
      else step();
    end
    chk(instruction == 32'h014C7020, "bp_instr_held", instruction, 32'h014C7020);
    chk(instr_pc == 32'd0, "bp_pc_held", instr_pc, 32'd0);
    clear_log();
    instr_ready = 1'b1;
    wait_halted(20);
    chk(get_pc(0) == 32'h0 && get_pc(2) == 32'h8, "bp_release_pcs", get_pc(2), 32'h8);
    chk(get_cyc(2) - get_cyc(0) == 2, "bp_release_rate", get_cyc(2) - get_cyc(0), 32'd2);
    chk(get_data(2) == 32'h01567024, "lockout_rom2", get_data(2), 32'h01567024);

    // Redirect in the fourth cycle of the run.
    run = 1'b0;
    step();
    load(8'd4, 32'h11112222);
    load(8'd5, 32'h33334444);
    load(8'd6, SENT);
    clear_log();
    run = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 4; i++) step();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0013;
    step();
    redirect = 1'b0;
    wait_halted(20);
`ifdef IFU_REDIRECT_EN
    chk(xfer_pc.size() == 4, "redir_count", xfer_pc.size(), 32'd4);
    chk(get_pc(1) == 32'h4 && get_pc(2) == 32'h10, "redir_pc", get_pc(2), 32'h10);
    chk(get_data(2) == 32'h11112222, "redir_data", get_data(2), 32'h11112222);
    chk(get_cyc(2) - get_cyc(1) == 2, "redir_latency", get_cyc(2) - get_cyc(1), 32'd2);
    // Redirect out of HALTED resumes fetching.
    clear_log();
    redirect = 1'b1;
    redirect_pc = 32'd0;
    step();
    redirect = 1'b0;
    chk(halted == 1'b0, "redir_leave_halt", {31'd0, halted}, 32'd0);
    wait_halted(20);
    chk(get_pc(0) == 32'h0 && get_data(0) == 32'h014C7020, "redir_resume", get_data(0), 32'h014C7020);
`else
    chk(xfer_pc.size() == 3, "noredir_count", xfer_pc.size(), 32'd3);
    chk(get_pc(2) == 32'h8, "noredir_seq_pc", get_pc(2), 32'h8);
`endif

    // Wrap-around past the last ROM word.
    run = 1'b0;
    step();
    for (int i = 0; i < 256; i++) load(i[7:0], {8'hA5, 8'h00, 8'h5A, i[7:0]});
    clear_log();
    run = 1'b1;
    for (int i = 0; i < 400 && xfer_pc.size() < 258; i++) step();
    chk(get_pc(255) == 32'h3FC, "wrap_last", get_pc(255), 32'h3FC);
    chk(get_pc(256) == 32'h400, "wrap_pc", get_pc(256), 32'h400);
    chk(get_data(256) == 32'hA5005A00, "wrap_data", get_data(256), 32'hA5005A00);

    // Mid-run reset while a word is being presented.
    chk(instr_valid, "mr_valid_before", {31'd0, instr_valid}, 32'd1);
    rst = 1'b0;
    step();
    chk(instr_valid == 1'b0, "mr_valid", {31'd0, instr_valid}, 32'd0);
    chk(instr_pc == 32'd0, "mr_pc", instr_pc, 32'd0);
    chk(halted == 1'b0, "mr_halted", {31'd0, halted}, 32'd0);
    rst = 1'b1;
    clear_log();
    for (int i = 0; i < 20 && xfer_pc.size() < 2; i++) step();
    chk(get_pc(0) == 32'd0, "mr_restart_pc", get_pc(0), 32'd0);
    chk(get_data(0) == 32'hA5005A00, "mr_rom_intact", get_data(0), 32'hA5005A00);

    run = 1'b0;
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
